// File: rtl/iecdrv_pkg.sv
// rtl/iecdrv_pkg.sv - shared types and constants for the IEC drive SD path
package iecdrv_pkg;

   localparam int IECDRV_MAX_DRV = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      XFER  = 2'd2,
      DRAIN = 2'd3
   } sdarb_state_t;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iecdrv_rr_pick.sv
// rtl/iecdrv_rr_pick.sv - round-robin picker: first pending index at or after ptr
module iecdrv_rr_pick import iecdrv_pkg::*; #(
   parameter int  N = 2,
   localparam int W = sel_width(N)
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [N-1:0] rot;
   logic [W-1:0] enc;
   int           sum;

   always_comb begin
      rot   = N'({pending, pending} >> ptr);
      valid = |rot;
      enc   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) enc = W'(k);
      end
      // Undo the rotation; ptr and enc are both below N so one wrap suffices.
      sum = int'(ptr) + int'(enc);
      if (sum >= N) sum = sum - N;
      idx = W'(sum);
   end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// rtl/iecdrv_sd_arbiter.sv - round-robin sharing of the host SD block port between drive track loaders
module iecdrv_sd_arbiter import iecdrv_pkg::*; #(
   parameter int  NDRV  = 2,
   parameter int  TMO_W = 26,
   localparam int SEL_W = sel_width(NDRV)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NDRV*32-1:0] req_lba,
   input  logic [NDRV*6-1:0]  req_blk_cnt,
   input  logic [NDRV-1:0]    req_rd,
   input  logic [NDRV-1:0]    req_wr,
   output logic [NDRV-1:0]    req_ack,
   output logic [31:0]        sd_lba,
   output logic [5:0]         sd_blk_cnt,
   output logic               sd_rd,
   output logic               sd_wr,
   input  logic               sd_ack,
   output logic [SEL_W-1:0]   sd_sel,
   output logic               sd_busy,
   output logic               sd_tmo
);

   // Fires on the REQ edge where the counter would reach all-ones: 2^TMO_W-1 cycles in REQ.
   localparam logic [TMO_W-1:0] WDOG_FIRE = ~TMO_W'(1);

   sdarb_state_t     state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [31:0]      lba_q, lba_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic             busy_q, busy_d;
   logic             tmo_q, tmo_d;
   logic [TMO_W-1:0] wdog_q, wdog_d;

   logic             pick_valid;
   logic [SEL_W-1:0] pick_idx;
   logic [SEL_W-1:0] next_ptr;

   iecdrv_rr_pick #(.N(NDRV)) u_pick (
      .pending (req_rd | req_wr),
      .ptr     (ptr_q),
      .valid   (pick_valid),
      .idx     (pick_idx)
   );

   assign next_ptr = (int'(sel_q) == NDRV - 1) ? '0 : sel_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= DRAIN;
         ptr_q   <= '0;
         sel_q   <= '0;
         lba_q   <= '0;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         lba_q   <= lba_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      lba_d   = lba_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      busy_d  = busy_q;
      tmo_d   = 1'b0;
      wdog_d  = wdog_q;
      case (state_q)
         IDLE: begin
            // A host ack still high from an aborted transfer must not be taken for ours.
            if (pick_valid && !sd_ack) begin
               state_d = REQ;
               sel_d   = pick_idx;
               lba_d   = req_lba[int'(pick_idx)*32 +: 32];
               cnt_d   = req_blk_cnt[int'(pick_idx)*6 +: 6];
               wr_d    = req_wr[pick_idx];
               rd_d    = !req_wr[pick_idx];
               busy_d  = 1'b1;
               wdog_d  = '0;
            end
         end
         REQ: begin
            if (sd_ack) begin
               state_d = XFER;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end else if (wdog_q == WDOG_FIRE) begin
               state_d = DRAIN;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               busy_d  = 1'b0;
               tmo_d   = 1'b1;
               ptr_d   = next_ptr;
            end else begin
               wdog_d  = wdog_q + 1'b1;
            end
         end
         XFER: begin
            if (!sd_ack) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               ptr_d   = next_ptr;
            end
         end
         DRAIN: begin
            if (!sd_ack) state_d = IDLE;
         end
         default: state_d = DRAIN;
      endcase
   end

   always_comb begin
      req_ack = '0;
      for (int i = 0; i < NDRV; i++) begin
         req_ack[i] = sd_ack && (state_q == REQ || state_q == XFER) && (sel_q == SEL_W'(i));
      end
   end

   assign sd_lba     = lba_q;
   assign sd_blk_cnt = cnt_q;
   assign sd_rd      = rd_q;
   assign sd_wr      = wr_q;
   assign sd_sel     = sel_q;
   assign sd_busy    = busy_q;
   assign sd_tmo     = tmo_q;

endmodule
